// File: rtl/sram_rd_arbiter_pkg.sv
// Shared types and constants for the two-requester SRAM read-port arbiter.
package sram_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/sram_rd_arbiter_if.sv
// One requester's burst-read channel: request (addr/len) and response (data/last).
// Both halves are valid/ready: a transfer happens in any cycle where valid && ready;
// the source holds valid and its payload stable until that cycle.
interface sram_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_WIDTH = 256
) ();
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;
  logic                  rsp_ready;

  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/sram_rd_fifo2.sv
// Two-entry fall-through FIFO for read data plus last flag; an empty FIFO
// presents the incoming push directly so a beat can pass through in one cycle.
module sram_rd_fifo2
  import sram_rd_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            count
);
  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH:0] mem_d [FIFO_DEPTH];
  logic [1:0]          count_q, count_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                bypass, wr_en, rd_en;
  logic [DATA_WIDTH:0] head;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_valid = (count_q != 2'd0) || push;
    out_data  = (count_q != 2'd0) ? head[DATA_WIDTH-1:0] : push_data;
    out_last  = (count_q != 2'd0) ? head[DATA_WIDTH]     : push_last;
    count     = count_q;

    // A beat that arrives into an empty FIFO and is taken at once is never stored.
    bypass = push && pop && (count_q == 2'd0);
    wr_en  = push && !bypass;
    rd_en  = pop && (count_q != 2'd0);

    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = {push_last, push_data};
    count_d  = count_q + {1'b0, wr_en} - {1'b0, rd_en};
    wr_ptr_d = wr_ptr_q ^ wr_en;
    rd_ptr_d = rd_ptr_q ^ rd_en;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/sram_rd_arbiter.sv
// Shares one SRAM read port between two burst requesters: round-robin whole-burst
// grants, one read per cycle with credit-based flow control and write-hazard stall.
module sram_rd_arbiter
  import sram_rd_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_rd_arbiter_if.slave      r0,
  sram_rd_arbiter_if.slave      r1,
  input  logic                  wr_snoop_en,
  input  logic [ADDR_WIDTH-1:0] wr_snoop_addr,
  output logic                  sram_ren,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  busy,
  output logic                  grant_id,
  output state_t                dbg_state
);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic                  grant_q, grant_d;
  logic                  rr_q, rr_d;
  logic                  busy_q, busy_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic                  win, accept, hazard, ren, last_issue, pop, rsp_ready_g;
  logic                  f_valid, f_last;
  logic [DATA_WIDTH-1:0] f_data;
  logic [1:0]            f_count;

  sram_rd_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (sram_rdata),
    .push_last (inflight_last_q),
    .pop       (pop),
    .out_valid (f_valid),
    .out_data  (f_data),
    .out_last  (f_last),
    .count     (f_count)
  );

  always_comb begin
    win = REQ0;
    if (r0.req_valid && r1.req_valid) win = ~rr_q;
    else if (r1.req_valid)            win = REQ1;
    accept = (state_q == ST_IDLE) && (r0.req_valid || r1.req_valid);

    // Reads in flight count against the buffer so a full FIFO is never pushed.
    hazard     = wr_snoop_en && (wr_snoop_addr == addr_q);
    ren        = (state_q == ST_ISSUE) && !hazard &&
                 (({1'b0, f_count} + {2'b00, inflight_q}) < 3'(FIFO_DEPTH));
    last_issue = (beat_q == len_q);

    rsp_ready_g = (grant_q == REQ1) ? r1.rsp_ready : r0.rsp_ready;
    pop         = f_valid && rsp_ready_g;

    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    beat_d          = beat_q;
    grant_d         = grant_q;
    rr_d            = rr_q;
    busy_d          = busy_q;
    inflight_d      = ren;
    inflight_last_d = ren && last_issue;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = (win == REQ1) ? r1.req_addr : r0.req_addr;
          len_d   = (win == REQ1) ? r1.req_len  : r0.req_len;
          beat_d  = '0;
          grant_d = win;
          rr_d    = win;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ren) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          beat_d = beat_q + LEN_WIDTH'(1);
          if (last_issue) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && f_last) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      beat_q          <= '0;
      grant_q         <= REQ0;
      rr_q            <= REQ1;
      busy_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      beat_q          <= beat_d;
      grant_q         <= grant_d;
      rr_q            <= rr_d;
      busy_q          <= busy_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  assign r0.req_ready = accept && (win == REQ0);
  assign r1.req_ready = accept && (win == REQ1);
  assign r0.rsp_valid = f_valid && (grant_q == REQ0);
  assign r1.rsp_valid = f_valid && (grant_q == REQ1);
  assign r0.rsp_data  = r0.rsp_valid ? f_data : '0;
  assign r1.rsp_data  = r1.rsp_valid ? f_data : '0;
  assign r0.rsp_last  = r0.rsp_valid && f_last;
  assign r1.rsp_last  = r1.rsp_valid && f_last;

  assign sram_ren   = ren;
  assign sram_raddr = addr_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Directed-plus-random bench for sram_rd_arbiter with an SRAM model and a
// sequential reference memory that yields the expected beats of every burst.
module tb_sram_rd_arbiter;
  import sram_rd_arbiter_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         wr_snoop_en;
  logic [9:0]   wr_snoop_addr;
  logic [255:0] wr_data;
  logic         sram_ren;
  logic [9:0]   sram_raddr;
  logic [255:0] sram_rdata;
  logic         busy;
  logic         grant_id;
  state_t       dbg_state;

  logic [255:0] mem     [1024];
  logic [255:0] ref_mem [1024];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  sram_rd_arbiter_if #(.ADDR_WIDTH(10), .LEN_WIDTH(8), .DATA_WIDTH(256)) bus0 ();
  sram_rd_arbiter_if #(.ADDR_WIDTH(10), .LEN_WIDTH(8), .DATA_WIDTH(256)) bus1 ();

  sram_rd_arbiter #(.DATA_WIDTH(256), .ADDR_WIDTH(10), .LEN_WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .r0            (bus0),
    .r1            (bus1),
    .wr_snoop_en   (wr_snoop_en),
    .wr_snoop_addr (wr_snoop_addr),
    .sram_ren      (sram_ren),
    .sram_raddr    (sram_raddr),
    .sram_rdata    (sram_rdata),
    .busy          (busy),
    .grant_id      (grant_id),
    .dbg_state     (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: read-old-data when a read and a write hit the same word in one cycle
  always @(posedge clk) begin
    if (sram_ren)    sram_rdata <= mem[sram_raddr];
    if (wr_snoop_en) mem[wr_snoop_addr] <= wr_data;
  end

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic ready_at(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.req_len = '0; bus0.rsp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.req_len = '0; bus1.rsp_ready = 1'b0;
    wr_snoop_en = 1'b0; wr_snoop_addr = '0; wr_data = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},     256'(busy), 256'(0));
    chk({tag, "_grant"},    256'(grant_id), 256'(0));
    chk({tag, "_ren"},      256'(sram_ren), 256'(0));
    chk({tag, "_raddr"},    256'(sram_raddr), 256'(0));
    chk({tag, "_r0_rdy"},   256'(bus0.req_ready), 256'(0));
    chk({tag, "_r1_rdy"},   256'(bus1.req_ready), 256'(0));
    chk({tag, "_r0_rv"},    256'(bus0.rsp_valid), 256'(0));
    chk({tag, "_r1_rv"},    256'(bus1.rsp_valid), 256'(0));
    chk({tag, "_r0_data"},  bus0.rsp_data, 256'(0));
    chk({tag, "_r1_data"},  bus1.rsp_data, 256'(0));
    chk({tag, "_r0_last"},  256'(bus0.rsp_last), 256'(0));
    chk({tag, "_r1_last"},  256'(bus1.rsp_last), 256'(0));
    chk({tag, "_state"},    256'(dbg_state), 256'(ST_IDLE));
  endtask

  // Drives one burst from requester id (assumed accepted in its first cycle) and
  // scoreboards address order, data, last flag, outstanding depth and timing.
  task automatic run_burst(input string tag, input logic id, input logic [9:0] addr,
                           input logic [7:0] len, input logic other_v, input int mode,
                           input logic hz_en, input logic [9:0] hz_addr, input int hz_cycle,
                           input int abort_after);
    logic [255:0] exp_q[$];
    logic         exp_l[$];
    logic [9:0]   exp_a[$];
    logic [9:0]   obs_a[$];
    int           ren_cyc[$];
    logic [255:0] hz_data, w_data;
    logic [9:0]   a;
    logic         w_rv, w_rl, w_rr, o_rv, w_qr, o_qr;
    int           issued, popped, first_rsp, c, nbeats;
    logic         done;

    hz_data = rand_word();
    nbeats  = int'(len) + 1;
    for (int i = 0; i < nbeats; i++) begin
      a = addr + 10'(i);
      exp_a.push_back(a);
      exp_q.push_back((hz_en && a == hz_addr) ? hz_data : ref_mem[a]);
      exp_l.push_back(i == nbeats - 1);
    end
    if (hz_en) ref_mem[hz_addr] = hz_data;

    issued = 0; popped = 0; first_rsp = -1; c = 0; done = 1'b0;
    while (!done && c < 300) begin
      @(negedge clk);
      if (c == 0) begin
        bus0.req_valid = (id == REQ0) ? 1'b1 : other_v;
        bus1.req_valid = (id == REQ1) ? 1'b1 : other_v;
        if (id == REQ0) begin bus0.req_addr = addr; bus0.req_len = len; end
        else            begin bus1.req_addr = addr; bus1.req_len = len; end
      end else if (c == 1) begin
        if (id == REQ0) bus0.req_valid = 1'b0;
        else            bus1.req_valid = 1'b0;
      end
      if (id == REQ0) begin bus0.rsp_ready = ready_at(mode, c); bus1.rsp_ready = 1'($urandom_range(0, 1)); end
      else            begin bus1.rsp_ready = ready_at(mode, c); bus0.rsp_ready = 1'($urandom_range(0, 1)); end
      wr_snoop_en   = hz_en && (c == hz_cycle);
      wr_snoop_addr = hz_addr;
      wr_data       = hz_data;
      #1;
      w_rv   = (id == REQ1) ? bus1.rsp_valid : bus0.rsp_valid;
      w_rl   = (id == REQ1) ? bus1.rsp_last  : bus0.rsp_last;
      w_rr   = (id == REQ1) ? bus1.rsp_ready : bus0.rsp_ready;
      w_data = (id == REQ1) ? bus1.rsp_data  : bus0.rsp_data;
      o_rv   = (id == REQ1) ? bus0.rsp_valid : bus1.rsp_valid;
      w_qr   = (id == REQ1) ? bus1.req_ready : bus0.req_ready;
      o_qr   = (id == REQ1) ? bus0.req_ready : bus1.req_ready;
      if (c == 0) begin
        chk({tag, "_idle_busy"}, 256'(busy), 256'(0));
        chk({tag, "_win_ready"}, 256'(w_qr), 256'(1));
        chk({tag, "_lose_ready"}, 256'(o_qr), 256'(0));
      end else begin
        chk({tag, "_no_accept"}, 256'({w_qr, o_qr}), 256'(0));
      end
      if (c == 1) begin
        chk({tag, "_grant_id"}, 256'(grant_id), 256'(id));
        chk({tag, "_busy"}, 256'(busy), 256'(1));
      end
      if (hz_en && c == hz_cycle) chk({tag, "_hazard_stall"}, 256'(sram_ren), 256'(0));
      if (sram_ren) begin
        obs_a.push_back(sram_raddr);
        ren_cyc.push_back(c);
        issued++;
      end
      chk({tag, "_outstanding"}, 256'(issued - popped <= 2), 256'(1));
      chk({tag, "_other_rsp_valid"}, 256'(o_rv), 256'(0));
      if (w_rv && first_rsp < 0) first_rsp = c;
      if (w_rv && w_rr) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_beat"}, 256'(1), 256'(0));
        end else begin
          chk({tag, "_data"}, w_data, exp_q.pop_front());
          chk({tag, "_last"}, 256'(w_rl), 256'(exp_l.pop_front()));
        end
        popped++;
        if (popped == nbeats || popped == abort_after) done = 1'b1;
      end
      c++;
    end
    chk({tag, "_completed"}, 256'(done), 256'(1));

    if (abort_after == 0) begin
      chk({tag, "_num_reads"}, 256'(obs_a.size()), 256'(nbeats));
      for (int i = 0; i < obs_a.size() && i < nbeats; i++)
        chk({tag, "_raddr"}, 256'(obs_a[i]), 256'(exp_a[i]));
      if (hz_en) begin
        for (int i = 0; i < obs_a.size(); i++)
          if (obs_a[i] == hz_addr) chk({tag, "_hazard_delay"}, 256'(ren_cyc[i]), 256'(hz_cycle + 1));
      end else if (mode == 0 && ren_cyc.size() == nbeats) begin
        chk({tag, "_first_ren"}, 256'(ren_cyc[0]), 256'(1));
        chk({tag, "_last_ren"}, 256'(ren_cyc[nbeats-1]), 256'(nbeats));
        chk({tag, "_first_rsp"}, 256'(first_rsp), 256'(2));
      end
    end
  endtask

  initial begin
    logic [9:0] ra;
    logic       rid;
    idle_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = rand_word();
      mem[i] <= ref_mem[i];
    end
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // simultaneous requests: r0 first (rr starts at r1), then r1, then r0 again
    run_burst("pair_a", REQ0, 10'h020, 8'd1, 1'b1, 0, 1'b0, 10'h0, 0, 0);
    run_burst("pair_b", REQ1, 10'h040, 8'd1, 1'b0, 0, 1'b0, 10'h0, 0, 0);
    run_burst("pair_c", REQ0, 10'h060, 8'd1, 1'b1, 0, 1'b0, 10'h0, 0, 0);
    run_burst("pair_d", REQ1, 10'h080, 8'd1, 1'b0, 0, 1'b0, 10'h0, 0, 0);

    run_burst("single",  REQ0, 10'h010, 8'd3, 1'b0, 0, 1'b0, 10'h0, 0, 0);
    run_burst("bkpress", REQ1, 10'h100, 8'd7, 1'b0, 1, 1'b0, 10'h0, 0, 0);
    run_burst("hazard",  REQ0, 10'h010, 8'd3, 1'b0, 0, 1'b1, 10'h012, 3, 0);
    run_burst("wrap",    REQ0, 10'h3FE, 8'd3, 1'b0, 0, 1'b0, 10'h0, 0, 0);
    run_burst("len0",    REQ1, 10'h200, 8'd0, 1'b0, 0, 1'b0, 10'h0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      rid = 1'($urandom_range(0, 1));
      ra  = 10'($urandom_range(0, 1023));
      run_burst("rand", rid, ra, 8'($urandom_range(0, 5)), 1'b0, $urandom_range(0, 2),
                1'b0, 10'h0, 0, 0);
    end

    // reset in the middle of a burst
    run_burst("pre_rst", REQ0, 10'h300, 8'd7, 1'b0, 0, 1'b0, 10'h0, 0, 2);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs_zero("mid_rst");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus0.rsp_ready = 1'b1;
      bus1.rsp_ready = 1'b1;
      #1;
      chk("post_rst_quiet", 256'({bus0.rsp_valid, bus1.rsp_valid, busy}), 256'(0));
    end
    run_burst("post_rst", REQ1, 10'h0A0, 8'd4, 1'b0, 0, 1'b0, 10'h0, 0, 0);

    @(negedge clk);
    idle_inputs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sram_rd_arbiter.md
Name: sram_rd_arbiter

Overview:
- Shares the single SRAM read port (1024 x 256) between two burst read requesters.
- Requester 0 is the pcie_axi_to_sram read engine; requester 1 is a secondary consumer (e.g. message inspector or DMA).
- Grants whole bursts round-robin, issues one SRAM read per cycle with flow control, and returns data through a 2-entry output buffer.
- Stalls a read that collides with a same-cycle write from pcie_msg_receiver, so freshly assembled data is always returned.

Parameters:
- DATA_WIDTH, 256, SRAM word width.
- ADDR_WIDTH, 10, SRAM word address width.
- LEN_WIDTH, 8, burst length field width (value = beats-1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- r0_req_valid  input  1  requester 0 burst request.
- r0_req_addr  input  ADDR_WIDTH  requester 0 start word address.
- r0_req_len  input  LEN_WIDTH  requester 0 beats-1.
- r0_req_ready  output  1  requester 0 request accepted.
- r0_rsp_valid  output  1  requester 0 read data valid.
- r0_rsp_data  output  DATA_WIDTH  requester 0 read data.
- r0_rsp_last  output  1  requester 0 final beat.
- r0_rsp_ready  input  1  requester 0 accepts data.
- r1_req_valid, r1_req_addr, r1_req_len, r1_req_ready, r1_rsp_valid, r1_rsp_data, r1_rsp_last, r1_rsp_ready: same directions, widths and meanings for requester 1.
- wr_snoop_en  input  1  SRAM write enable (the receiver's sram_wen).
- wr_snoop_addr  input  ADDR_WIDTH  SRAM write address.
- sram_ren  output  1  SRAM read enable.
- sram_raddr  output  ADDR_WIDTH  SRAM read address.
- sram_rdata  input  DATA_WIDTH  SRAM read data, valid 1 cycle after sram_ren.
- busy  output  1  a burst is in progress.
- grant_id  output  1  owner of the current or last burst.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, FSM returns to IDLE, buffer and in-flight flag cleared, rr pointer = 1 so requester 0 wins first.
  - Reset mid-burst abandons the burst. No rsp_valid until a new request is accepted.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE, selecting the winner:
  - Only one requester valid: that requester wins.
  - Both valid: the requester != rr pointer wins.
  - The winner's req_ready is asserted combinationally in the same cycle; the other requester's req_ready stays 0.
- IDLE, on acceptance:
  - Latch addr, len and grant_id.
  - Set rr pointer = winner.
  - busy=1, go to ISSUE.
- ISSUE:
  - sram_ren=1 when (buffer_count + inflight) < 2 and not hazard.
  - hazard = wr_snoop_en && wr_snoop_addr == current address.
  - Each issued read increments the address modulo 2^ADDR_WIDTH (0x3FF wraps to 0x000) and decrements the remaining count.
  - After issuing beat len, go to DRAIN.
  - A hazard delays the read by exactly one cycle per colliding write; no beat is dropped or duplicated.
- Data path:
  - One cycle after sram_ren, sram_rdata is pushed into the 2-entry FIFO, tagged with last = (final beat).
  - The FIFO head drives rsp_data and rsp_last of the granted requester only; the other requester's rsp_valid is 0.
  - Pop on rsp_valid && rsp_ready. Push and pop in the same cycle are both legal; a full FIFO is never pushed (guaranteed by the issue rule).
- DRAIN: once the last beat is popped, go to IDLE and set busy=0 in the next cycle. A new request may be accepted in the cycle after returning to IDLE.
- Throughput: 1 beat/cycle sustained with rsp_ready held high. First rsp_valid appears 2 cycles after the req_ready cycle.
- req_len=0 is a single beat with rsp_last on that beat.
- Requests that arrive during a burst are held by the requester and not accepted until IDLE.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/ISSUE/DRAIN).
  - Requester ID constants REQ0/REQ1.
  - FIFO depth constant = 2.
- One sub-module: sram_rd_fifo2, a 2-entry data+last FIFO with count, push and pop.
- Arbitration and FSM stay in the top module.

Test Plan:
1. Single burst: r0 addr=0x010, len=3, rsp_ready=1.
   - sram_raddr 0x010..0x013 on consecutive cycles.
   - 4 rsp beats matching SRAM contents; rsp_last on beat 4 only.
   - busy low afterwards.
2. Simultaneous requests after reset: r0 and r1 both valid, len=1.
   - r0 granted first, then r1.
   - Next simultaneous pair: r0 granted first again (alternation, because rr=r1 after the second burst).
   - r1 never sees r0 data.
3. Backpressure: r1 addr=0x100, len=7, rsp_ready toggled 1,0,0,1...
   - No more than 2 beats are outstanding.
   - All 8 beats are delivered in order with no loss or duplication.
   - sram_ren is deasserted while the buffer is full.
4. Write hazard: wr_snoop_en=1, wr_snoop_addr=0x012 in the cycle the read of 0x012 would issue.
   - Read delayed one cycle.
   - Returned data equals the newly written value.
5. Wrap: r0 addr=0x3FE, len=3.
   - sram_raddr sequence 0x3FE, 0x3FF, 0x000, 0x001.
6. Reset mid-burst: rst_n=0 after 2 beats of a len=7 burst.
   - All outputs 0 next cycle.
   - A fresh r1 request after release completes correctly.
